button_events: RTL



---
 rtl/button_pkg.sv | 14 +
 rtl/button_events_if.sv | 19 +
 rtl/button_timer.sv | 35 +++
 rtl/button_events.sv | 138 +++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared button state encoding and ms-to-cycle helper
package button_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESSED   = 2'd1,
        LONG_HELD = 2'd2
    } btn_state_t;

    function automatic int ms_to_cycles(input int freq, input int ms);
        return freq / 1000 * ms;
    endfunction

endpackage

// File: rtl/button_events_if.sv
// rtl/button_events_if.sv - debounced level in, decoded button events out
interface button_events_if;
    logic level;
    logic press_pulse;
    logic release_pulse;
    logic long_pulse;
    logic repeat_pulse;
    logic held;

    modport master (
        output level,
        input  press_pulse, release_pulse, long_pulse, repeat_pulse, held
    );

    modport slave (
        input  level,
        output press_pulse, release_pulse, long_pulse, repeat_pulse, held
    );
endinterface

// File: rtl/button_timer.sv
// rtl/button_timer.sv - clear/enable hold counter with terminal-count compare
module button_timer #(
    parameter int TW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_i,
    input  logic          en_i,
    input  logic [TW-1:0] tc_val_i,
    output logic          tc_o
);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == tc_val_i);

endmodule

// File: rtl/button_events.sv
// rtl/button_events.sv - press/release/long/repeat event decoder; BUTTON_REPEAT_EN enables auto-repeat
module button_events #(
    parameter int CLK_FREQ  = 50000000,
    parameter int LONG_MS   = 1000,
    parameter int REPEAT_MS = 200
) (
    input logic              clk,
    input logic              reset,
    button_events_if.slave   bus
);
    import button_pkg::*;

    localparam int LONG_CYC   = ms_to_cycles(CLK_FREQ, LONG_MS);
    localparam int REPEAT_CYC = ms_to_cycles(CLK_FREQ, REPEAT_MS);
    localparam int MAX_CYC    = (LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC;
    localparam int TW         = $clog2(MAX_CYC + 1);

    localparam logic [TW-1:0] LONG_TC = TW'(LONG_CYC - 1);
`ifdef BUTTON_REPEAT_EN
    localparam logic [TW-1:0] REPEAT_TC = TW'(REPEAT_CYC - 1);
`endif

    localparam logic [1:0] ST_IDLE      = IDLE;
    localparam logic [1:0] ST_PRESSED   = PRESSED;
    localparam logic [1:0] ST_LONG_HELD = LONG_HELD;

    logic [1:0]    state_q, state_d;
    logic          prev_q;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;
    logic          repeat_q, repeat_d;
    logic          held_q, held_d;

    logic          tmr_clr, tmr_en, tmr_tc;
    logic [TW-1:0] tmr_tc_val;
    logic          rise, fall;

    assign rise = bus.level & ~prev_q;
    assign fall = ~bus.level & prev_q;

    // Release is tested before the threshold so it always wins a same-cycle tie.
    always_comb begin
        state_d    = state_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        long_d     = 1'b0;
        repeat_d   = 1'b0;
        tmr_clr    = 1'b0;
        tmr_en     = 1'b0;
        tmr_tc_val = LONG_TC;
        case (state_q)
            ST_IDLE: begin
                tmr_clr = 1'b1;
                if (rise) begin
                    press_d = 1'b1;
                    state_d = ST_PRESSED;
                end
            end
            ST_PRESSED: begin
                if (fall) begin
                    release_d = 1'b1;
                    tmr_clr   = 1'b1;
                    state_d   = ST_IDLE;
                end else if (tmr_tc) begin
                    long_d  = 1'b1;
                    tmr_clr = 1'b1;
                    state_d = ST_LONG_HELD;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_LONG_HELD: begin
`ifdef BUTTON_REPEAT_EN
                tmr_tc_val = REPEAT_TC;
`endif
                if (fall) begin
                    release_d = 1'b1;
                    tmr_clr   = 1'b1;
                    state_d   = ST_IDLE;
                end
`ifdef BUTTON_REPEAT_EN
                else if (tmr_tc) begin
                    repeat_d = 1'b1;
                    tmr_clr  = 1'b1;
                end else begin
                    tmr_en = 1'b1;
                end
`endif
            end
            default: begin
                tmr_clr = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
        held_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            prev_q    <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= bus.level;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            held_q    <= held_d;
        end
    end

    button_timer #(.TW(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (tmr_clr),
        .en_i     (tmr_en),
        .tc_val_i (tmr_tc_val),
        .tc_o     (tmr_tc)
    );

    assign bus.press_pulse   = press_q;
    assign bus.release_pulse = release_q;
    assign bus.long_pulse    = long_q;
    assign bus.held          = held_q;
`ifdef BUTTON_REPEAT_EN
    assign bus.repeat_pulse  = repeat_q;
`else
    assign bus.repeat_pulse  = 1'b0;
`endif

endmodule
